// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM stage of a 5-stage pipeline.
// A load or store held in EX/MEM is latched in IDLE, counted through LATENCY
// BUSY cycles, committed to the word array on the last BUSY edge, and then
// reported for one DONE cycle. The pipeline is stalled from the first cycle
// the request is visible until the DONE cycle, where it is released.
//
// Ports
//   clk_i     in   1  clock, rising edge
//   rst_i     in   1  synchronous reset, active-low
//   MemRd_i   in   1  load request
//   MemWr_i   in   1  store request (takes priority over MemRd_i)
//   Addr_i    in  32  byte address; only the word index bits are used
//   WrData_i  in  32  store data
//   RdData_o  out 32  load data, registered, held until the next aligned load
//   Stall_o   out  1  freeze PC, IF/ID, ID/EX, EX/MEM
//   Done_o    out  1  one-cycle pulse: request finished
//   Err_o     out  1  one-cycle pulse with Done_o: request was misaligned
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic [31:0] RdData_o,
  output logic        Stall_o,
  output logic        Done_o,
  output logic        Err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [CW-1:0]   count;
  logic [AW-1:0]   latIdx;
  logic [31:0]     latData;
  logic            latWr;
  logic            latMis;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            unusedAddrBits;

  assign req = MemRd_i | MemWr_i;

  // Address bits above the word index are deliberately ignored, so accesses
  // wrap modulo 4*DEPTH_WORDS bytes.
  assign unusedAddrBits = ^Addr_i[31:AW+2];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    nextState = state;
    Stall_o   = 1'b0;
    Done_o    = 1'b0;
    Err_o     = 1'b0;
    unique case (state)
      IDLE: begin
        Stall_o = req;
        if (req) nextState = BUSY;
      end
      BUSY: begin
        Stall_o = 1'b1;
        if (count == '0) nextState = DONE;
      end
      DONE: begin
        // The same instruction still sits in EX/MEM; inputs are ignored.
        Done_o    = 1'b1;
        Err_o     = latMis;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // A request held on the inputs during reset must not stall the pipeline.
    if (!rst_i) Stall_o = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch, latency counter, memory commit
  // --------------------------------------------------------------------------
  // NOTE: the word array is cleared by reset, so it sits in registers rather
  // than an inferred RAM macro (which cannot be reset in one cycle).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count    <= '0;
      latIdx   <= '0;
      latData  <= '0;
      latWr    <= 1'b0;
      latMis   <= 1'b0;
      RdData_o <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            latIdx  <= Addr_i[AW+1:2];
            latData <= WrData_i;
            latWr   <= MemWr_i;
            latMis  <= (Addr_i[1:0] != 2'b00);
            count   <= CW'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else if (!latMis) begin
            // Only the final BUSY edge touches memory, so an aborted request
            // leaves no trace.
            if (latWr) mem[latIdx] <= latData;
            else       RdData_o    <= mem[latIdx];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Instance A runs with LATENCY=3, instance
// B with LATENCY=1; both have DEPTH_WORDS=256. Inputs change 1 ns after a
// rising edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A (LATENCY=3)
  logic        rstA, rdA, wrA;
  logic [31:0] addrA, wdA, rdDataA;
  logic        stallA, doneA, errA;

  // Instance B (LATENCY=1)
  logic        rstB, rdB, wrB;
  logic [31:0] addrB, wdB, rdDataB;
  logic        stallB, doneB, errB;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dutA (
    .clk_i(clk_i), .rst_i(rstA), .MemRd_i(rdA), .MemWr_i(wrA),
    .Addr_i(addrA), .WrData_i(wdA), .RdData_o(rdDataA),
    .Stall_o(stallA), .Done_o(doneA), .Err_o(errA)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dutB (
    .clk_i(clk_i), .rst_i(rstB), .MemRd_i(rdB), .MemWr_i(wrB),
    .Addr_i(addrB), .WrData_i(wdB), .RdData_o(rdDataB),
    .Stall_o(stallB), .Done_o(doneB), .Err_o(errB)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      rdB = rd; wrB = wr; addrB = addr; wdB = data;
    end else begin
      rdA = rd; wrA = wr; addrA = addr; wdA = data;
    end
  endtask

  // Runs one request starting at posedge+1 of its cycle 0 and returns at
  // posedge+1 of the IDLE cycle that follows DONE. Checks Stall/Done/Err in
  // every cycle and RdData in the DONE cycle.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit expErr, input logic [31:0] expRd);
    int lat = sel ? 1 : 3;
    string who = sel ? "B" : "A";
    drive(sel, rd, wr, addr, data);
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk_i);
      check($sformatf("%s stall a=%h c%0d", who, addr, c),
            sel ? stallB : stallA, (c <= lat));
      check($sformatf("%s done a=%h c%0d", who, addr, c),
            sel ? doneB : doneA, (c == lat + 1));
      check($sformatf("%s err a=%h c%0d", who, addr, c),
            sel ? errB : errA, (c == lat + 1) ? expErr : 1'b0);
      if (c == lat + 1)
        check($sformatf("%s rdata a=%h", who, addr),
              sel ? rdDataB : rdDataA, expRd);
      @(posedge clk_i); #1;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h1);   // request held during reset
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst stall", stallA, 1'b0);
    check("rst done",  doneA,  1'b0);
    check("rst err",   errA,   1'b0);
    check("rst rdata", rdDataA, 32'h0);
    @(posedge clk_i); #1;
    rstA = 1'b1; rstB = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("idle no req stall", stallA, 1'b0);
    @(posedge clk_i); #1;

    // Aligned write, then reads; RdData is untouched by the write.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0,        1'b0, 32'h0);
    // Misaligned read and write: error pulse, no side effects.
    access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h11, 32'h11111111, 1'b1, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    // Read and write together: write wins, RdData holds.
    access(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678);
    // Wrap-around: 0x400 aliases word 0.
    access(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h12345678);
    access(1'b0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b0, 32'hA5A5A5A5);

    // Reset during BUSY aborts the write.
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF);   // cycle 0
    @(posedge clk_i); #1;                           // cycle 1
    @(posedge clk_i); #1;                           // cycle 2
    rstA = 1'b0;
    @(posedge clk_i); #1;                           // cycle 3
    @(negedge clk_i);
    check("midrst stall", stallA, 1'b0);
    check("midrst done",  doneA,  1'b0);
    check("midrst rdata", rdDataA, 32'h0);
    @(posedge clk_i); #1;
    rstA = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h8,  32'h0, 1'b0, 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

    // LATENCY=1: preload, then two back-to-back loads (stall 1,1,0,1,1,0).
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 1'b0, 32'h0);
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFE0001, 1'b0, 32'h0);
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0, 32'h0BADF00D);
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 32'hCAFE0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
